protocolo_dac: RTL and testbench
================================

PROTOCOLO_DAC -- requirements
Module: protocolo_dac

Interface
REQ-001 SHALL have parameter DIV_HALF, default 2: SCLK half-period in Clock_Muestreo cycles; legal range 1..15.
REQ-002 SHALL have Clock_Muestreo  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start  input  1  request to send one frame; sampled on each rising edge.
REQ-005 SHALL have Dato  input  12  data word, captured on an accepted start.
REQ-006 SHALL have modo  input  4  control nibble, captured together with Dato.
REQ-007 SHALL have CS  output  1  active-low frame select.
REQ-008 SHALL have SCLK  output  1  serial clock; idles low.
REQ-009 SHALL have data_DAC  output  1  serial data, MSB first.
REQ-010 SHALL have busy  output  1  high while a frame is in progress, including the FIN cycle.
REQ-011 SHALL have done  output  1  one-cycle pulse at the end of each frame.
REQ-012 SHALL have perdido  output  1  sticky flag: a start request was dropped.

Function
REQ-013 SHALL register every output; no output is driven combinationally from inputs.
REQ-014 SHALL implement the states INICIO, ENVIAR and FIN.
REQ-015 Frame SHALL be the 16-bit word {modo, Dato}, sent bit 15 first.
REQ-016 INICIO with start=1 at edge 0 SHALL:
- load the frame into a shift register;
- after edge 0: CS=0, busy=1, SCLK=0, data_DAC=frame[15];
- go to ENVIAR.
REQ-017 ENVIAR SHALL toggle SCLK every DIV_HALF edges. Rising edges fall at edge DIV_HALF*(2i+1), falling edges at edge 2*DIV_HALF*(i+1), for i = 0..15.
REQ-018 At each falling SCLK edge except the 16th, the shift register SHALL shift left, so data_DAC changes only while SCLK is low and is stable at every rising edge.
REQ-019 After the 16th falling edge (edge 32*DIV_HALF) SHALL enter FIN with SCLK=0, CS=1 and done=1 for exactly one cycle.
REQ-020 An internal bit counter SHALL count 0..15 and SHALL NOT wrap within a frame.
REQ-021 A start while busy=1 SHALL be captured ({modo, Dato} included) into a one-deep pending buffer if that buffer is empty.
REQ-022 A start while busy=1 and the pending buffer is full SHALL be dropped and SHALL set perdido=1; perdido clears only on reset.
REQ-023 Leaving FIN with the pending buffer full SHALL start the pending frame at the next edge, exactly as in REQ-016, and SHALL empty the buffer. CS stays high for exactly one cycle between frames.
REQ-024 A start in the same cycle as FIN:
- if the pending buffer is empty, SHALL be treated as the next frame (CS back low at the next edge);
- if the pending buffer is full, SHALL be handled per REQ-022.
REQ-025 In INICIO, a start with the pending buffer empty SHALL be accepted directly per REQ-016.
REQ-026 Unreachable state encodings SHALL return to INICIO on the next edge with CS=1.

Reset
REQ-027 Reset SHALL immediately force:
- CS=1, SCLK=0, data_DAC=0;
- busy=0, done=0, perdido=0;
- shift register and bit counter to 0;
- pending buffer to empty;
- state to INICIO.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse. After release, nothing is transmitted until a new start.

Verification
REQ-029 DIV_HALF=2, modo=4'hA, Dato=12'h5C3, one-cycle start:
- CS low for 64 cycles;
- 16 SCLK rising edges sample 1010_0101_1100_0011;
- done high one cycle at edge 64; busy falls at edge 65.
REQ-030 DIV_HALF=1, back-to-back starts with Dato=12'hFFF then 12'h000:
- second frame is buffered;
- CS high exactly one cycle between frames;
- the two done pulses are 33 cycles apart; perdido=0.
REQ-031 Three starts within one frame: the third is dropped, perdido=1 and stays 1, and exactly two frames are sent.
REQ-032 Reset pulse at edge 20 of a frame: CS=1 and SCLK=0 immediately, no done pulse, and the next start sends a complete frame.
REQ-033 Start held high continuously, DIV_HALF=2: frames repeat every 65 cycles, the data bits at the SCLK rising edges match the values of {modo, Dato} when each frame was loaded, and perdido goes high on the first start that arrives while a frame is running and the buffer is already full.

Source files
------------

// File: rtl/protocolo_dac.sv
// protocolo_dac -- serialises a 16-bit word {modo, Dato} to a SPI-style DAC.
//
// Frame format: CS low, 16 bits MSB first on data_DAC, sampled by the DAC on
// the rising edges of SCLK. SCLK idles low and toggles every DIV_HALF cycles
// of Clock_Muestreo. A one-deep pending buffer absorbs one start request that
// arrives while a frame is running; further requests are dropped and flagged.
//
// Ports
//   Clock_Muestreo  in   system clock, all state updates on its rising edge
//   reset           in   asynchronous, active-high reset
//   start           in   request to send one frame (level sampled every edge)
//   Dato[11:0]      in   data word, captured on an accepted start
//   modo[3:0]       in   control nibble, captured together with Dato
//   CS              out  active-low frame select
//   SCLK            out  serial clock, idles low
//   data_DAC        out  serial data, MSB first
//   busy            out  high while a frame is in progress (FIN included)
//   done            out  one-cycle pulse at the end of each frame
//   perdido         out  sticky: a start request was dropped (reset clears)
//   estado_dbg[1:0] out  current FSM state, for observation only
//
// Handshake: start is a level request. It is accepted on any rising edge where
// the block can take it (idle, FIN with an empty buffer, or running with an
// empty pending buffer); there is no ready signal, a refused request only
// raises perdido.

module protocolo_dac #(
   parameter int DIV_HALF = 2              // SCLK half-period, 1..15
) (
   input  logic        Clock_Muestreo,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] Dato,
   input  logic [3:0]  modo,
   output logic        CS,
   output logic        SCLK,
   output logic        data_DAC,
   output logic        busy,
   output logic        done,
   output logic        perdido,
   output logic [1:0]  estado_dbg
);

   typedef enum logic [1:0] {
      INICIO = 2'd0,
      ENVIAR = 2'd1,
      FIN    = 2'd2
   } estado_t;

   localparam logic [3:0] DIV_LAST = 4'(DIV_HALF - 1);

   estado_t     estado;
   logic [15:0] shift_reg;
   logic [3:0]  bit_cnt;
   logic [3:0]  div_cnt;
   logic        pend_full;
   logic [15:0] pend_frame;

   // Frame source and load condition for a new frame. The pending buffer has
   // priority: it is only ever full while busy, so in INICIO the live inputs
   // are always the source.
   logic [15:0] frame_sel;
   logic        carga;

   always_comb begin
      frame_sel = pend_full ? pend_frame : {modo, Dato};
      carga     = 1'b0;
      if (estado == INICIO && start)
         carga = 1'b1;
      else if (estado == FIN && (pend_full || start))
         carga = 1'b1;
   end

   assign estado_dbg = estado;

   always_ff @(posedge Clock_Muestreo or posedge reset) begin
      if (reset) begin
         estado     <= INICIO;
         shift_reg  <= 16'd0;
         bit_cnt    <= 4'd0;
         div_cnt    <= 4'd0;
         pend_full  <= 1'b0;
         pend_frame <= 16'd0;
         CS         <= 1'b1;
         SCLK       <= 1'b0;
         data_DAC   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         perdido    <= 1'b0;
      end else begin
         done <= 1'b0;

         if (carga) begin
            // Common frame start for INICIO and for chaining out of FIN.
            estado    <= ENVIAR;
            shift_reg <= frame_sel;
            data_DAC  <= frame_sel[15];
            bit_cnt   <= 4'd0;
            div_cnt   <= 4'd0;
            CS        <= 1'b0;
            SCLK      <= 1'b0;
            busy      <= 1'b1;
            if (pend_full) begin
               pend_full <= 1'b0;
               // The buffer is still full during this edge, so a start here
               // has nowhere to go.
               if (start)
                  perdido <= 1'b1;
            end
         end else begin
            case (estado)
               INICIO: begin
                  CS   <= 1'b1;
                  SCLK <= 1'b0;
                  busy <= 1'b0;
               end

               ENVIAR: begin
                  if (start) begin
                     if (!pend_full) begin
                        pend_full  <= 1'b1;
                        pend_frame <= {modo, Dato};
                     end else begin
                        perdido <= 1'b1;
                     end
                  end

                  if (div_cnt == DIV_LAST) begin
                     div_cnt <= 4'd0;
                     if (!SCLK) begin
                        SCLK <= 1'b1;
                     end else begin
                        // Falling SCLK edge: data only moves while SCLK is low.
                        SCLK <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                           estado   <= FIN;
                           CS       <= 1'b1;
                           done     <= 1'b1;
                           data_DAC <= 1'b0;
                        end else begin
                           shift_reg <= {shift_reg[14:0], 1'b0};
                           data_DAC  <= shift_reg[14];
                           bit_cnt   <= bit_cnt + 4'd1;
                        end
                     end
                  end else begin
                     div_cnt <= div_cnt + 4'd1;
                  end
               end

               FIN: begin
                  // No pending frame and no start (otherwise carga): go idle.
                  estado <= INICIO;
                  busy   <= 1'b0;
               end

               default: begin
                  estado   <= INICIO;
                  CS       <= 1'b1;
                  SCLK     <= 1'b0;
                  data_DAC <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_protocolo_dac.sv
// Bench for protocolo_dac. Two instances share one stimulus stream: index 0
// uses DIV_HALF=2, index 1 uses DIV_HALF=1. The driver pushes the expected
// 16-bit frame for every frame that must complete; a monitor per instance
// rebuilds each frame from data_DAC at SCLK rising edges and pops/compares on
// every done pulse. Timing properties (done edge, busy fall, CS gap, done
// spacing) are recorded by the monitors and compared by the driver.

module tb_protocolo_dac;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] Dato  = 12'd0;
   logic [3:0]  modo  = 4'd0;

   logic        cs_w   [2];
   logic        sclk_w [2];
   logic        data_w [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic        perd_w [2];
   logic [1:0]  est_w  [2];

   logic [15:0] exp_q [2][$];

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int done_last [2];
   int done_prev [2];
   int done_cnt  [2];
   int busy_fall [2];
   int last_gap  [2];

   localparam int IDLE_LIMIT = 1000;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   protocolo_dac #(.DIV_HALF(2)) dut_lento (
      .Clock_Muestreo(clk), .reset(reset), .start(start), .Dato(Dato), .modo(modo),
      .CS(cs_w[0]), .SCLK(sclk_w[0]), .data_DAC(data_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .perdido(perd_w[0]), .estado_dbg(est_w[0]));

   protocolo_dac #(.DIV_HALF(1)) dut_rapido (
      .Clock_Muestreo(clk), .reset(reset), .start(start), .Dato(Dato), .modo(modo),
      .CS(cs_w[1]), .SCLK(sclk_w[1]), .data_DAC(data_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .perdido(perd_w[1]), .estado_dbg(est_w[1]));

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int dh_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // ---------------- monitors / scoreboard ----------------
   for (genvar g = 0; g < 2; g++) begin : g_mon
      localparam int DH = (g == 0) ? 2 : 1;
      initial begin
         logic        prev_sclk = 1'b0;
         logic        prev_cs   = 1'b1;
         logic        prev_busy = 1'b0;
         logic        prev_data = 1'b0;
         logic [15:0] shreg     = 16'd0;
         logic [15:0] expv;
         int          nbits     = 0;
         int          cs_low    = 0;
         int          cs_high   = 0;
         done_last[g] = 0; done_prev[g] = 0; done_cnt[g] = 0;
         busy_fall[g] = 0; last_gap[g] = 0;
         forever begin
            @(negedge clk);
            if (reset) begin
               nbits  = 0;
               shreg  = 16'd0;
               cs_low = 0;
            end else begin
               if (!cs_w[g]) cs_low++;
               if (sclk_w[g] && prev_sclk)
                  check($sformatf("data_stable[%0d]", g), data_w[g], prev_data);
               if (sclk_w[g] && !prev_sclk) begin
                  shreg = {shreg[14:0], data_w[g]};
                  nbits++;
               end
               if (!cs_w[g] && prev_cs) last_gap[g] = cs_high;
               if (prev_busy && !busy_w[g]) busy_fall[g] = cyc;
               if (done_w[g]) begin
                  done_prev[g] = done_last[g];
                  done_last[g] = cyc;
                  done_cnt[g]++;
                  if (exp_q[g].size() == 0) begin
                     check($sformatf("unexpected_done[%0d]", g), 1, 0);
                  end else begin
                     expv = exp_q[g].pop_front();
                     check($sformatf("frame_data[%0d]", g), shreg, expv);
                  end
                  check($sformatf("sclk_rises[%0d]", g), nbits, 16);
                  check($sformatf("cs_low_len[%0d]", g), cs_low, 32 * DH);
                  check($sformatf("busy_in_fin[%0d]", g), busy_w[g], 1'b1);
                  nbits  = 0;
                  cs_low = 0;
               end
            end
            cs_high   = cs_w[g] ? cs_high + 1 : 0;
            prev_sclk = sclk_w[g];
            prev_cs   = cs_w[g];
            prev_busy = busy_w[g];
            prev_data = data_w[g];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [3:0] m, input logic [11:0] d);
      @(posedge clk);
      #1;
      start = 1'b1;
      modo  = m;
      Dato  = d;
   endtask

   task automatic push_both(input logic [15:0] w);
      exp_q[0].push_back(w);
      exp_q[1].push_back(w);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_w[0] || busy_w[1]) && n < IDLE_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_in_time"}, (n < IDLE_LIMIT), 1'b1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("%s_frames_left[%0d]", tag, i), exp_q[i].size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0;
      int dc [2];

      // Reset state while reset is held.
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_cs[%0d]", i), cs_w[i], 1'b1);
         check($sformatf("rst_sclk[%0d]", i), sclk_w[i], 1'b0);
         check($sformatf("rst_data[%0d]", i), data_w[i], 1'b0);
         check($sformatf("rst_busy[%0d]", i), busy_w[i], 1'b0);
         check($sformatf("rst_done[%0d]", i), done_w[i], 1'b0);
         check($sformatf("rst_perdido[%0d]", i), perd_w[i], 1'b0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // Single frame A/5C3 -> 1010_0101_1100_0011.
      issue(4'hA, 12'h5C3);
      push_both(16'hA5C3);
      @(posedge clk);
      #1;
      e0 = cyc;
      start = 1'b0;
      wait_idle("single");
      for (int i = 0; i < 2; i++) begin
         check($sformatf("single_done_edge[%0d]", i), done_last[i] - e0, 32 * dh_of(i));
         check($sformatf("single_busy_fall[%0d]", i), busy_fall[i] - e0, 32 * dh_of(i) + 1);
      end

      // Back-to-back: second request goes through the pending buffer.
      issue(4'h3, 12'hFFF);
      push_both(16'h3FFF);
      issue(4'h3, 12'h000);
      push_both(16'h3000);
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("b2b");
      for (int i = 0; i < 2; i++) begin
         check($sformatf("b2b_cs_gap[%0d]", i), last_gap[i], 1);
         check($sformatf("b2b_done_spacing[%0d]", i), done_last[i] - done_prev[i], 32 * dh_of(i) + 1);
         check($sformatf("b2b_perdido[%0d]", i), perd_w[i], 1'b0);
      end

      // Three requests in one frame: the third is dropped.
      issue(4'h1, 12'h234);
      push_both(16'h1234);
      issue(4'h2, 12'hABC);
      push_both(16'h2ABC);
      issue(4'h3, 12'h777);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 2; i++)
         check($sformatf("drop_perdido_set[%0d]", i), perd_w[i], 1'b1);
      wait_idle("drop");
      for (int i = 0; i < 2; i++)
         check($sformatf("drop_perdido_sticky[%0d]", i), perd_w[i], 1'b1);

      // Reset pulse in the middle of a frame: abort, no done.
      issue(4'hC, 12'h0F0);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort_cs[%0d]", i), cs_w[i], 1'b1);
         check($sformatf("abort_sclk[%0d]", i), sclk_w[i], 1'b0);
         check($sformatf("abort_perdido_clr[%0d]", i), perd_w[i], 1'b0);
         dc[i] = done_cnt[i];
      end
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (100) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort_no_done[%0d]", i), done_cnt[i] - dc[i], 0);
         check($sformatf("abort_idle_cs[%0d]", i), cs_w[i], 1'b1);
         check($sformatf("abort_idle_busy[%0d]", i), busy_w[i], 1'b0);
      end
      issue(4'h6, 12'h9A5);
      push_both(16'h69A5);
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("after_abort");

      // Start held high from edge 0 through edge 139.
      // DIV_HALF=2: frames load at 0, 65, 130, 195 -> 4 frames.
      // DIV_HALF=1: frames load at 0, 33, 66, 99, 132, 165 -> 6 frames.
      issue(4'h5, 12'hA3C);
      for (int k = 0; k < 4; k++) exp_q[0].push_back(16'h5A3C);
      for (int k = 0; k < 6; k++) exp_q[1].push_back(16'h5A3C);
      @(posedge clk);           // edge 0: frame loaded
      @(posedge clk);           // edge 1: captured into pending
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("held_perdido_e1[%0d]", i), perd_w[i], 1'b0);
      @(posedge clk);           // edge 2: buffer full, dropped
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("held_perdido_e2[%0d]", i), perd_w[i], 1'b1);
      repeat (137) @(posedge clk);
      #1 start = 1'b0;
      wait_idle("held");
      for (int i = 0; i < 2; i++) begin
         check($sformatf("held_period[%0d]", i), done_last[i] - done_prev[i], 32 * dh_of(i) + 1);
         check($sformatf("held_cs_gap[%0d]", i), last_gap[i], 1);
         check($sformatf("held_perdido_end[%0d]", i), perd_w[i], 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
